// File: rtl/seq_div8.sv
// Sequential restoring divider: one quotient bit per clock, unsigned WIDTH-bit
// quotient and remainder, with a dedicated divide-by-zero result path.
module seq_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] q_sh_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dz_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             zero_div_s;
    logic             last_s;
    logic             keep_s;
    logic [WIDTH:0]   t_s;
    logic [WIDTH+1:0] s_s;
    logic [WIDTH-1:0] r_nx_s;
    logic [WIDTH-1:0] q_nx_s;

    // Trial subtract as T + ~{0,D} + 1; bit WIDTH+1 is the carry-out (no borrow).
    function automatic logic [WIDTH+1:0] trial_sub(input logic [WIDTH:0] t,
                                                   input logic [WIDTH-1:0] d);
        trial_sub = {1'b0, t} + {1'b0, ~{1'b0, d}} + {{(WIDTH + 1){1'b0}}, 1'b1};
    endfunction

    assign accept_s   = start & (state_r != RUN);
    assign zero_div_s = (divisor == {WIDTH{1'b0}});
    assign last_s     = (count_r == CW'(WIDTH - 1));

    // One restoring iteration; the kept difference is always below D, so bit WIDTH is clear.
    always_comb begin
        t_s    = {r_r, q_sh_r[WIDTH-1]};
        s_s    = trial_sub(t_s, d_r);
        keep_s = s_s[WIDTH+1] & ~s_s[WIDTH];
        if (keep_s) begin
            r_nx_s = s_s[WIDTH-1:0];
            q_nx_s = {q_sh_r[WIDTH-2:0], 1'b1};
        end else begin
            r_nx_s = t_s[WIDTH-1:0];
            q_nx_s = {q_sh_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nx_s = zero_div_s ? DONE : RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and registered status flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s != RUN);
            busy_r  <= (state_nx_s == RUN);
            done_r  <= (state_nx_s == DONE);
        end
    end

    // Operand latch, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sh_r      <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            count_r     <= {CW{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dz_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        q_sh_r  <= dividend;
                        d_r     <= divisor;
                        r_r     <= {WIDTH{1'b0}};
                        count_r <= {CW{1'b0}};
                        dz_r    <= zero_div_s;
                        if (zero_div_s) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                        end
                    end
                end
                RUN: begin
                    q_sh_r  <= q_nx_s;
                    r_r     <= r_nx_s;
                    count_r <= count_r + CW'(1);
                    if (last_s) begin
                        quotient_r  <= q_nx_s;
                        remainder_r <= r_nx_s;
                    end
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign ready       = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dz_r;

endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8: directed corner cases plus random pairs
// checked against plain integer division and the division invariant.
module tb_seq_div8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       ready, busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int n_cmp = 0;
    int n_err = 0;

    // Results the DUT should currently be presenting.
    logic [7:0] exp_q = 8'd0;
    logic [7:0] exp_r = 8'd0;
    logic       exp_dz = 1'b0;

    seq_div8 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Call at a negedge: issues one request, waits for done (bounded), checks
    // latency, busy length, held outputs during the run and the final result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int glitch_at);
        int lat, busy_cnt, ia, ib, eq, er;
        ia = int'(a);
        ib = int'(b);
        eq = (ib == 0) ? 255 : ia / ib;
        er = (ib == 0) ? ia : ia % ib;
        check_val("ready_at_req", 32'(ready), 32'd1);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            check_val("hold_q", 32'(quotient), 32'(exp_q));
            check_val("hold_r", 32'(remainder), 32'(exp_r));
            check_val("dz_clr", 32'(div_by_zero), 32'd0);
            check_val("ready_run", 32'(ready), 32'd0);
            if (busy === 1'b1) busy_cnt++;
            if (lat == glitch_at) begin
                start = 1'b1; dividend = 8'd9; divisor = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_val("latency", 32'(lat), (ib == 0) ? 32'd0 : 32'd8);
        check_val("busy_len", 32'(busy_cnt), (ib == 0) ? 32'd0 : 32'd8);
        check_val("ready_done", 32'(ready), 32'd1);
        check_val("busy_done", 32'(busy), 32'd0);
        check_val("quot", 32'(quotient), 32'(eq));
        check_val("rem", 32'(remainder), 32'(er));
        check_val("dz", 32'(div_by_zero), (ib == 0) ? 32'd1 : 32'd0);
        if (ib != 0) begin
            check_val("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check_val("rem_lt_div", 32'(remainder < b), 32'd1);
        end
        exp_q = 8'(eq);
        exp_r = 8'(er);
        exp_dz = (ib == 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(ready), 32'd1);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_q"}, 32'(quotient), 32'd0);
        check_val({tag, "_r"}, 32'(remainder), 32'd0);
        check_val({tag, "_dz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Basic divide and the boundary set.
        run_op(8'd200, 8'd7, -1);
        @(negedge clk);
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("idle_hold_q", 32'(quotient), 32'd28);
        run_op(8'd255, 8'd1, -1);
        run_op(8'd255, 8'd255, -1);
        run_op(8'd5, 8'd9, -1);
        run_op(8'd0, 8'd3, -1);
        @(negedge clk);

        // Divide by zero, then a normal divide clears the flag.
        run_op(8'hAB, 8'd0, -1);
        @(negedge clk);
        check_val("dz_held", 32'(div_by_zero), 32'd1);
        check_val("dz_done_pulse", 32'(done), 32'd0);
        run_op(8'd50, 8'd6, -1);

        // Start while busy is ignored.
        @(negedge clk);
        run_op(8'd100, 8'd3, 3);

        // Back-to-back: new request in the done cycle.
        run_op(8'd77, 8'd10, -1);
        run_op(8'hAB, 8'd0, -1);
        run_op(8'd9, 8'd0, -1);
        run_op(8'd17, 8'd5, -1);
        @(negedge clk);

        // Reset in the middle of an operation.
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) begin
            @(negedge clk);
            check_val("rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        exp_q = 8'd0; exp_r = 8'd0; exp_dz = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check_val("abort_no_done", 32'(done), 32'd0);
        end
        run_op(8'd13, 8'd4, -1);

        // Random regression.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] ra, rb;
            int g;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check_val("rnd_done_pulse", 32'(done), 32'd0);
            end
            run_op(ra, rb, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
